// File: rtl/fb_pkg.sv
// Shared frame-buffer types: default geometry, read-owner tags and arbiter states.
package fb_pkg;
  localparam int ADDR_W_DEF    = 17;
  localparam int DATA_W_DEF    = 32;
  localparam int NUM_ADDRS_DEF = 115200;

  typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_DRAW} owner_e;
  typedef enum logic [1:0] {IDLE, FETCH, DRAW} arb_state_e;

  // oob marks a read whose address was out of range: its data returns as zero
  typedef struct packed {
    owner_e own;
    logic   oob;
  } rd_tag_t;
endpackage

// File: rtl/rd_tag_pipe.sv
// Owner-tag delay line: a tag entered in the grant cycle emerges DEPTH cycles later,
// lined up with the memory read data.
module rd_tag_pipe
  import fb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst_,
  input  rd_tag_t i_tag,
  output rd_tag_t o_tag
);
  rd_tag_t r_pipe [DEPTH];

  always_ff @(posedge clk) begin
    if (rst_) begin
      for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= i_tag;
      for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_tag = r_pipe[DEPTH-1];
endmodule

// File: rtl/frame_mem_arbiter.sv
// Two-port frame-buffer arbiter: fetch has priority, draw is forced in after STARVE_MAX fetches.
// Define FRAME_MEM_ARB_STATS_EN to enable the grant statistics counters.
module frame_mem_arbiter
  import fb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int NUM_ADDRS  = NUM_ADDRS_DEF,
  parameter int RD_LAT     = 2,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic [DATA_W-1:0] f_rdata,
  output logic              f_rvalid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_rvalid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err_oob,
  input  logic              err_clr,
  output logic [31:0]       stat_fetch,
  output logic [31:0]       stat_draw,
  output logic [15:0]       stat_starve
);
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [ADDR_W:0] LIM = (ADDR_W+1)'(NUM_ADDRS);

  arb_state_e       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_starve, w_starve_nxt;
  logic             w_force, w_f_sel, w_d_sel, w_f_oob, w_d_oob, w_oob, r_err;
  rd_tag_t          w_tag_in, w_tag_out;

  assign w_f_oob = ({1'b0, f_addr} >= LIM);
  assign w_d_oob = ({1'b0, d_addr} >= LIM);
  assign w_force = d_req && (r_starve == CNT_W'(STARVE_MAX));

  always_ff @(posedge clk) begin
    if (rst_) begin
      r_state  <= IDLE;
      r_starve <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_starve <= w_starve_nxt;
    end
  end

  // The starve count only survives a run of back-to-back fetch grants with draw waiting
  always_comb begin
    w_state_nxt  = IDLE;
    w_starve_nxt = '0;
    w_f_sel      = 1'b0;
    w_d_sel      = 1'b0;
    if (!rst_) begin
      if (f_req && !w_force) begin
        w_f_sel     = 1'b1;
        w_state_nxt = FETCH;
        if (d_req) begin
          if (r_state != FETCH)                        w_starve_nxt = CNT_W'(1);
          else if (r_starve == CNT_W'(STARVE_MAX))     w_starve_nxt = r_starve;
          else                                         w_starve_nxt = r_starve + 1'b1;
        end
      end else if (d_req) begin
        w_d_sel     = 1'b1;
        w_state_nxt = DRAW;
      end
    end
  end

  assign f_gnt     = w_f_sel;
  assign d_gnt     = w_d_sel;
  assign w_oob     = (w_f_sel & w_f_oob) | (w_d_sel & w_d_oob);
  assign mem_en    = (w_f_sel | w_d_sel) & ~w_oob;
  assign mem_we    = w_d_sel & d_we & ~w_d_oob;
  assign mem_addr  = w_d_sel ? d_addr : f_addr;
  assign mem_wdata = d_wdata;

  always_comb begin
    w_tag_in     = '0;
    w_tag_in.oob = w_oob;
    if (w_f_sel)                w_tag_in.own = OWN_FETCH;
    else if (w_d_sel && !d_we)  w_tag_in.own = OWN_DRAW;
  end

  rd_tag_pipe #(.DEPTH(RD_LAT)) u_tag_pipe (
    .clk   (clk),
    .rst_  (rst_),
    .i_tag (w_tag_in),
    .o_tag (w_tag_out)
  );

  assign f_rvalid = ~rst_ & (w_tag_out.own == OWN_FETCH);
  assign d_rvalid = ~rst_ & (w_tag_out.own == OWN_DRAW);
  assign f_rdata  = w_tag_out.oob ? '0 : mem_rdata;
  assign d_rdata  = w_tag_out.oob ? '0 : mem_rdata;

  // A fresh violation outranks a clear issued in the same cycle
  always_ff @(posedge clk) begin
    if (rst_) r_err <= 1'b0;
    else      r_err <= w_oob | (r_err & ~err_clr);
  end
  assign err_oob = r_err & ~rst_;

`ifdef FRAME_MEM_ARB_STATS_EN
  logic [31:0] r_stat_fetch, r_stat_draw;
  logic [15:0] r_stat_starve;

  always_ff @(posedge clk) begin
    if (rst_) begin
      r_stat_fetch  <= '0;
      r_stat_draw   <= '0;
      r_stat_starve <= '0;
    end else begin
      if (w_f_sel)           r_stat_fetch  <= r_stat_fetch + 1'b1;
      if (w_d_sel)           r_stat_draw   <= r_stat_draw + 1'b1;
      if (w_d_sel && f_req)  r_stat_starve <= r_stat_starve + 1'b1;
    end
  end

  assign stat_fetch  = r_stat_fetch;
  assign stat_draw   = r_stat_draw;
  assign stat_starve = r_stat_starve;
`else
  assign stat_fetch  = '0;
  assign stat_draw   = '0;
  assign stat_starve = '0;
`endif
endmodule

// File: tb/tb_frame_mem_arbiter.sv
// Directed bench for frame_mem_arbiter: table of single-cycle vectors plus hand sequences,
// with a behavioural memory and an expected read-return pipe.
module tb_frame_mem_arbiter;
  import fb_pkg::*;

  localparam int AW  = 17;
  localparam int DW  = 32;
  localparam int NA  = 115200;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst_, f_req, d_req, d_we, err_clr;
  logic [AW-1:0] f_addr, d_addr, mem_addr;
  logic [DW-1:0] d_wdata, f_rdata, d_rdata, mem_wdata, mem_rdata;
  logic          f_gnt, f_rvalid, d_gnt, d_rvalid, mem_en, mem_we, err_oob;
  logic [31:0]   stat_fetch, stat_draw;
  logic [15:0]   stat_starve;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  frame_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .NUM_ADDRS(NA), .RD_LAT(LAT), .STARVE_MAX(8)) dut (
    .clk(clk), .rst_(rst_),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rdata(f_rdata), .f_rvalid(f_rvalid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rdata(d_rdata), .d_rvalid(d_rvalid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .err_oob(err_oob), .err_clr(err_clr),
    .stat_fetch(stat_fetch), .stat_draw(stat_draw), .stat_starve(stat_starve)
  );

  // Behavioural memory with LAT-cycle read latency; idle slots carry a junk marker
  logic [31:0] mem    [NA];
  logic [31:0] shadow [NA];
  logic [31:0] rd_pipe [LAT];

  function automatic logic [31:0] pat(int a);
    return 32'hC0DE_0000 ^ 32'(a);
  endfunction

  always @(posedge clk) begin
    if (mem_en && mem_we) mem[int'(mem_addr)] <= mem_wdata;
    rd_pipe[0] <= (mem_en && !mem_we) ? mem[int'(mem_addr)] : 32'hBAD0_BAD0;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[LAT-1];

  typedef struct { owner_e own; logic [31:0] data; } exp_t;
  exp_t ep [2];
  logic e_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, check against expected grants and the read-return model
  task automatic cyc(input logic rst, input logic fr, input logic [AW-1:0] fa,
                     input logic dr, input logic dwe, input logic [AW-1:0] da,
                     input logic [31:0] dwd, input logic clr, input logic efg, input logic edg);
    logic fo, dob, en, we;
    exp_t nw;
    @(posedge clk); #1;
    rst_ = rst; f_req = fr; f_addr = fa; d_req = dr; d_we = dwe; d_addr = da;
    d_wdata = dwd; err_clr = clr;
    #1;
    fo  = (int'(fa) >= NA);
    dob = (int'(da) >= NA);
    en  = (efg && !fo) || (edg && !dob);
    we  = edg && dwe && !dob;
    chk("f_gnt", f_gnt, efg);
    chk("d_gnt", d_gnt, edg);
    chk("mem_en", mem_en, en);
    chk("mem_we", mem_we, we);
    if (en) chk("mem_addr", mem_addr, edg ? da : fa);
    if (we) chk("mem_wdata", mem_wdata, dwd);
    chk("err_oob", err_oob, rst ? 1'b0 : e_err);
    chk("f_rvalid", f_rvalid, !rst && ep[1].own == OWN_FETCH);
    chk("d_rvalid", d_rvalid, !rst && ep[1].own == OWN_DRAW);
    chk("one_rvalid", f_rvalid & d_rvalid, 1'b0);
    if (!rst && ep[1].own == OWN_FETCH) chk("f_rdata", f_rdata, ep[1].data);
    if (!rst && ep[1].own == OWN_DRAW)  chk("d_rdata", d_rdata, ep[1].data);
    nw = '{OWN_NONE, 32'h0};
    if (efg)              nw = '{OWN_FETCH, fo  ? 32'h0 : shadow[int'(fa)]};
    else if (edg && !dwe) nw = '{OWN_DRAW,  dob ? 32'h0 : shadow[int'(da)]};
    if (we) shadow[int'(da)] = dwd;
    e_err = rst ? 1'b0 : (((efg && fo) || (edg && dob)) | (e_err & !clr));
    if (rst) begin
      ep[0] = '{OWN_NONE, 32'h0};
      ep[1] = '{OWN_NONE, 32'h0};
    end else begin
      ep[1] = ep[0];
      ep[0] = nw;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  typedef struct {
    logic fr; logic [AW-1:0] fa; logic dr; logic dwe; logic [AW-1:0] da;
    logic [31:0] dwd; logic clr;
    logic efg; logic edg; logic een; logic eerr;
  } vec_t;
  vec_t tbl [11];

  initial begin
    logic [15:0] starve0;
    tbl[0]  = '{1, 5,      0, 0, 0,      32'h0,        0, 1, 0, 1, 0};
    tbl[1]  = '{0, 0,      1, 1, 7,      32'h1111_1111, 0, 0, 1, 1, 0};
    tbl[2]  = '{1, 9,      1, 0, 7,      32'h0,        0, 1, 0, 1, 0};
    tbl[3]  = '{1, 115200, 0, 0, 0,      32'h0,        0, 1, 0, 0, 0};
    tbl[4]  = '{0, 0,      0, 0, 0,      32'h0,        0, 0, 0, 0, 1};
    tbl[5]  = '{0, 0,      0, 0, 0,      32'h0,        1, 0, 0, 0, 1};
    tbl[6]  = '{0, 0,      0, 0, 0,      32'h0,        0, 0, 0, 0, 0};
    tbl[7]  = '{0, 0,      1, 0, 115201, 32'h0,        1, 0, 1, 0, 0};
    tbl[8]  = '{0, 0,      0, 0, 0,      32'h0,        0, 0, 0, 0, 1};
    tbl[9]  = '{0, 0,      1, 1, 115199, 32'h2222_2222, 1, 0, 1, 1, 1};
    tbl[10] = '{0, 0,      0, 0, 0,      32'h0,        0, 0, 0, 0, 0};

    for (int i = 0; i < NA; i++) begin
      mem[i]    = pat(i);
      shadow[i] = pat(i);
    end
    for (int i = 0; i < LAT; i++) rd_pipe[i] = 32'hBAD0_BAD0;
    ep[0] = '{OWN_NONE, 32'h0};
    ep[1] = '{OWN_NONE, 32'h0};
    e_err = 1'b0;
    rst_ = 1'b1; f_req = 0; f_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; err_clr = 0;

    // Reset, then fetch streams addresses 0..3
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    for (int a = 0; a < 4; a++) cyc(0, 1, AW'(a), 0, 0, 0, 0, 0, 1, 0);
    idle(2);

    for (int i = 0; i < 11; i++) begin
      cyc(0, tbl[i].fr, tbl[i].fa, tbl[i].dr, tbl[i].dwe, tbl[i].da, tbl[i].dwd, tbl[i].clr,
          tbl[i].efg, tbl[i].edg);
      chk($sformatf("tbl%0d_mem_en", i), mem_en, tbl[i].een);
      chk($sformatf("tbl%0d_err_oob", i), err_oob, tbl[i].eerr);
    end
    idle(2);

    // Starvation: 8 fetch grants then one forced draw grant, twice
    starve0 = stat_starve;
    for (int i = 0; i < 18; i++) cyc(0, 1, 21, 1, 0, 20, 0, 0, (i % 9) != 8, (i % 9) == 8);
    idle(2);
`ifdef FRAME_MEM_ARB_STATS_EN
    chk("stat_starve_delta", stat_starve - starve0, 16'd2);
`else
    chk("stat_starve_tied", {16'h0, starve0}, 32'h0);
`endif

    // Write the last valid word, read it back through fetch
    cyc(0, 0, 0, 1, 1, 115199, 32'hDEAD_BEEF, 0, 0, 1);
    cyc(0, 1, 115199, 0, 0, 0, 0, 0, 1, 0);
    idle(2);
    chk("last_word_rdata", f_rdata, 32'hDEAD_BEEF);

    // Alternating single-cycle draw and fetch reads
    cyc(0, 0, 0, 1, 0, 10, 0, 0, 0, 1);
    cyc(0, 1, 11, 0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0, 12, 0, 0, 0, 1);
    cyc(0, 1, 13, 0, 0, 0, 0, 0, 1, 0);
    idle(2);

    // Reads in flight at reset are dropped; grants resume right after
    cyc(0, 1, 115200, 0, 0, 0, 0, 0, 1, 0);
    cyc(0, 1, 3, 0, 0, 0, 0, 0, 1, 0);
    cyc(1, 1, 3, 1, 1, 4, 32'h5, 0, 0, 0);
    chk("rst_stat_fetch", stat_fetch, 32'h0);
    cyc(0, 1, 4, 0, 0, 0, 0, 0, 1, 0);
    idle(3);

`ifdef FRAME_MEM_ARB_STATS_EN
    chk("stat_fetch", stat_fetch, 32'd1);
    chk("stat_draw", stat_draw, 32'd0);
`else
    chk("stat_fetch_tied", stat_fetch, 32'h0);
    chk("stat_draw_tied", stat_draw, 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
